// File: rtl/control_multiciclo.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/mem/writeback for the 32-bit datapath
// and runs bounded req/ready handshakes with instruction and data memory.
module control_multiciclo #(
  parameter int OPC_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             zero_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             reg_we_o,
  output logic             sel_mux1_o,
  output logic             sel_mux2_o,
  output logic             sel_mux3_o,
  output logic             sel_mux4_o,
  output logic [1:0]       alu_op_o,
  output logic             instr_done_o,
  output logic             illegal_op_o,
  output logic             bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'h00);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'h23);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'h2B);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'h04);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'h08);

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             cause_q, cause_d;   // 1 = bus timeout, 0 = illegal opcode
  logic             timeout_hit;
  logic             opc_legal;

  assign timeout_hit = (wait_q == CNT_W'(TIMEOUT - 1));
  assign opc_legal   = (opcode_i == OP_R)  || (opcode_i == OP_LW)  || (opcode_i == OP_SW) ||
                       (opcode_i == OP_BEQ) || (opcode_i == OP_ADDI);

  // Reset drops state to IDLE at once, so every write enable deasserts without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      wait_q  <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    wait_d       = wait_q;
    cause_d      = cause_q;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    reg_we_o     = 1'b0;
    sel_mux1_o   = 1'b0;
    sel_mux2_o   = 1'b0;
    sel_mux3_o   = 1'b0;
    sel_mux4_o   = 1'b0;
    alu_op_o     = ALU_ADD;
    instr_done_o = 1'b0;
    illegal_op_o = 1'b0;
    bus_err_o    = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          cause_d = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_DECODE: begin
        opc_d = opcode_i;
        if (opc_legal) begin
          state_d = S_EXEC;
        end else begin
          cause_d = 1'b0;
          state_d = S_ERR;
        end
      end

      S_EXEC: begin
        if (opc_q == OP_R) begin
          alu_op_o = ALU_FUNCT;
          state_d  = S_WB;
        end else if (opc_q == OP_LW || opc_q == OP_SW) begin
          sel_mux4_o = 1'b1;
          state_d    = S_MEM;
        end else if (opc_q == OP_ADDI) begin
          sel_mux4_o = 1'b1;
          state_d    = S_WB;
        end else begin
          alu_op_o     = ALU_SUB;
          sel_mux3_o   = 1'b1;
          pc_we_o      = zero_i;
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end
      end

      // Address stays on the ALU output (base + immediate) for the whole access.
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (opc_q == OP_SW);
        sel_mux4_o = 1'b1;
        if (dmem_ready_i) begin
          if (opc_q == OP_SW) begin
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          cause_d = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_WB: begin
        reg_we_o     = 1'b1;
        instr_done_o = 1'b1;
        sel_mux1_o   = (opc_q == OP_R);
        sel_mux2_o   = (opc_q == OP_LW);
        state_d      = S_FETCH;
      end

      S_ERR: begin
        illegal_op_o = ~cause_q;
        bus_err_o    = cause_q;
        state_d      = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase

    // Any state change starts a fresh wait window for the next FETCH/MEM.
    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Testbench for control_multiciclo: an instruction-level model expands each instruction into
// its expected per-cycle control trace, which is replayed against the DUT cycle by cycle.
module tb_control_multiciclo;

  localparam int TIMEOUT = 15;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [14:0] E_NONE  = 15'h0000;
  localparam logic [14:0] E_IMREQ = 15'h4000;
  localparam logic [14:0] E_DREQ  = 15'h2000;
  localparam logic [14:0] E_DWE   = 15'h1000;
  localparam logic [14:0] E_IRWE  = 15'h0800;
  localparam logic [14:0] E_PCWE  = 15'h0400;
  localparam logic [14:0] E_REGWE = 15'h0200;
  localparam logic [14:0] E_M1    = 15'h0100;
  localparam logic [14:0] E_M2    = 15'h0080;
  localparam logic [14:0] E_M3    = 15'h0040;
  localparam logic [14:0] E_M4    = 15'h0020;
  localparam logic [14:0] E_ALUFN = 15'h0010;
  localparam logic [14:0] E_ALUSB = 15'h0008;
  localparam logic [14:0] E_DONE  = 15'h0004;
  localparam logic [14:0] E_ILL   = 15'h0002;
  localparam logic [14:0] E_BUS   = 15'h0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic       sel_mux1, sel_mux2, sel_mux3, sel_mux4;
  logic [1:0] alu_op;
  logic       instr_done, illegal_op, bus_err;

  int nCmp = 0;
  int nFail = 0;

  logic [8:0]  stimQ[$];
  logic [14:0] expQ[$];
  string       tagQ[$];

  control_multiciclo #(.OPC_W(6), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero),
    .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .reg_we_o(reg_we),
    .sel_mux1_o(sel_mux1), .sel_mux2_o(sel_mux2), .sel_mux3_o(sel_mux3), .sel_mux4_o(sel_mux4),
    .alu_op_o(alu_op), .instr_done_o(instr_done), .illegal_op_o(illegal_op), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] ropc();
    return 6'($urandom);
  endfunction

  task automatic pushCycle(input logic [5:0] opc, input logic z, input logic ir, input logic dr,
                           input logic [14:0] e, input string tag);
    stimQ.push_back({opc, z, ir, dr});
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // Expected trace of one instruction; iWait/dWait are ready-low cycles before ready rises.
  task automatic planInstr(input logic [5:0] opc, input logic z, input int iWait, input int dWait);
    logic [14:0] memExp;
    bit isLegal, isSw, isLw, isR;
    isLegal = opc inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
    isSw = (opc == OP_SW);
    isLw = (opc == OP_LW);
    isR  = (opc == OP_R);
    for (int k = 0; k < ((iWait < TIMEOUT) ? iWait : TIMEOUT); k++)
      pushCycle(ropc(), rbit(), 1'b0, rbit(), E_IMREQ, "fetch_wait");
    if (iWait >= TIMEOUT) begin
      pushCycle(ropc(), rbit(), rbit(), rbit(), E_BUS, "fetch_bus_err");
      return;
    end
    pushCycle(ropc(), rbit(), 1'b1, rbit(), E_IMREQ | E_IRWE | E_PCWE, "fetch");
    pushCycle(opc, rbit(), rbit(), rbit(), E_NONE, "decode");
    if (!isLegal) begin
      pushCycle(ropc(), rbit(), rbit(), rbit(), E_ILL, "illegal_err");
      return;
    end
    if (opc == OP_BEQ) begin
      pushCycle(ropc(), z, rbit(), rbit(), E_ALUSB | E_M3 | E_DONE | (z ? E_PCWE : E_NONE), "beq_exec");
      return;
    end
    pushCycle(ropc(), rbit(), rbit(), rbit(), isR ? E_ALUFN : E_M4, "exec");
    if (isLw || isSw) begin
      memExp = E_DREQ | E_M4 | (isSw ? E_DWE : E_NONE);
      for (int k = 0; k < ((dWait < TIMEOUT) ? dWait : TIMEOUT); k++)
        pushCycle(ropc(), rbit(), rbit(), 1'b0, memExp, "mem_wait");
      if (dWait >= TIMEOUT) begin
        pushCycle(ropc(), rbit(), rbit(), rbit(), E_BUS, "mem_bus_err");
        return;
      end
      pushCycle(ropc(), rbit(), rbit(), 1'b1, memExp | (isSw ? E_DONE : E_NONE), "mem");
      if (isSw) return;
    end
    pushCycle(ropc(), rbit(), rbit(), rbit(),
              E_REGWE | E_DONE | (isR ? E_M1 : E_NONE) | (isLw ? E_M2 : E_NONE), "wb");
  endtask

  task automatic applyStimulus(input logic [8:0] s);
    opcode     = s[8:3];
    zero       = s[2];
    imem_ready = s[1];
    dmem_ready = s[0];
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] e);
    logic [14:0] obs;
    obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, sel_mux1, sel_mux2,
           sel_mux3, sel_mux4, alu_op, instr_done, illegal_op, bus_err};
    nCmp++;
    assert (obs === e) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Called just after a rising edge; plays n queued cycles (all of them if n < 0).
  task automatic runQueue(input int n);
    int done = 0;
    while (stimQ.size() > 0 && (n < 0 || done < n)) begin
      applyStimulus(stimQ.pop_front());
      @(negedge clk);
      checkOutput(tagQ.pop_front(), expQ.pop_front());
      @(posedge clk);
      #1;
      done++;
    end
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushCycle(ropc(), rbit(), rbit(), rbit(), E_NONE, "idle");
  endtask

  initial begin
    int r, iw, dw;
    logic [5:0] op;

    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    opcode     = OP_R;
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_hold", E_NONE);
    end

    releaseReset();
    planInstr(OP_R, 1'b0, 0, 0);
    runQueue(-1);

    planInstr(OP_LW, 1'b0, 0, 3);
    runQueue(-1);

    planInstr(OP_BEQ, 1'b1, 0, 0);
    planInstr(OP_BEQ, 1'b0, 0, 0);
    runQueue(-1);

    planInstr(6'h3F, 1'b0, 0, 0);
    runQueue(-1);

    planInstr(OP_ADDI, 1'b0, TIMEOUT, 0);
    planInstr(OP_ADDI, 1'b0, TIMEOUT - 1, 0);
    planInstr(OP_SW, 1'b0, 0, 0);
    runQueue(-1);

    planInstr(OP_SW, 1'b0, 0, 5);
    runQueue(4);
    applyStimulus(stimQ.pop_front());
    @(negedge clk);
    checkOutput("sw_mem_before_rst", expQ.pop_front());
    #2 rst = 1'b1;
    #1 checkOutput("sw_async_rst", E_NONE);
    stimQ.delete();
    expQ.delete();
    tagQ.delete();
    @(negedge clk);
    checkOutput("sw_rst_hold", E_NONE);
    releaseReset();
    planInstr(OP_ADDI, 1'b0, 1, 0);
    runQueue(-1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    op = OP_R;
        2, 6:    op = OP_LW;
        3, 7:    op = OP_SW;
        4:       op = OP_BEQ;
        5, 8:    op = OP_ADDI;
        default: op = ropc();
      endcase
      iw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2) : $urandom_range(0, 2);
      dw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2) : $urandom_range(0, 3);
      planInstr(op, rbit(), iw, dw);
      runQueue(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
